// File: rtl/vs_pkg.sv
// rtl/vs_pkg.sv - shared constants, state encoding and lane slicing helper for the top-K search core
package vs_pkg;

    localparam logic VS_MODE_DOT = 1'b0;
    localparam logic VS_MODE_L2  = 1'b1;

    localparam int VS_LANES  = 4;
    localparam int VS_EW     = 8;
    localparam int VS_ACCW   = 32;
    localparam int VS_VID_W  = 10;
    localparam int VS_DIM_W  = 8;
    localparam int VS_ADDR_W = 12;
    localparam int VS_K      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vs_state_e;

    // Bit offset of element a (hi=0) or b (hi=1) of a lane within a memory word.
    function automatic int lane_off(input int lane, input int ew, input bit hi);
        return (2 * lane + (hi ? 1 : 0)) * ew;
    endfunction

endpackage

// File: rtl/vs_topk_core_if.sv
// rtl/vs_topk_core_if.sv - synchronous vector RAM read port
interface vs_topk_core_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
) ();
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (output mem_rd_en, output mem_addr, input  mem_data);
    modport slave  (input  mem_rd_en, input  mem_addr, output mem_data);
endinterface

// File: rtl/vs_topk_insert.sv
// rtl/vs_topk_insert.sv - sorted top-K register list with single-cycle compare/shift insert
module vs_topk_insert #(
    parameter int K     = 4,
    parameter int ACCW  = 32,
    parameter int VID_W = 10,
    parameter int CW    = $clog2(K + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic                   ins_valid,
    input  logic signed [ACCW-1:0] ins_score,
    input  logic [VID_W-1:0]       ins_id,
    output logic [CW-1:0]          count,
    output logic [K*ACCW-1:0]      score_flat,
    output logic [K*VID_W-1:0]     id_flat
);

    logic signed [ACCW-1:0] score_q [K];
    logic signed [ACCW-1:0] score_d [K];
    logic [VID_W-1:0]       id_q    [K];
    logic [VID_W-1:0]       id_d    [K];
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;
    logic                   found;
    int                     pos;

    always_comb begin
        score_d = score_q;
        id_d    = id_q;
        count_d = count_q;
        found   = 1'b0;
        pos     = 0;
        // Strict compare keeps an earlier id ahead of a later one with equal score.
        for (int i = 0; i < K; i++) begin
            if (!found && (i >= int'(count_q) || ins_score > score_q[i])) begin
                found = 1'b1;
                pos   = i;
            end
        end
        if (clr) begin
            for (int i = 0; i < K; i++) begin
                score_d[i] = '0;
                id_d[i]    = '0;
            end
            count_d = '0;
        end else if (ins_valid && found) begin
            for (int i = K - 1; i > 0; i--) begin
                if (i > pos) begin
                    score_d[i] = score_q[i-1];
                    id_d[i]    = id_q[i-1];
                end
            end
            score_d[pos] = ins_score;
            id_d[pos]    = ins_id;
            if (int'(count_q) < K) count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < K; i++) begin
                score_q[i] <= '0;
                id_q[i]    <= '0;
            end
            count_q <= '0;
        end else begin
            score_q <= score_d;
            id_q    <= id_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        for (int i = 0; i < K; i++) begin
            score_flat[i*ACCW +: ACCW] = score_q[i];
            id_flat[i*VID_W +: VID_W]  = id_q[i];
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vs_topk_core.sv
// rtl/vs_topk_core.sv - streaming dot/L2 vector search keeping a sorted top-K of (score, id)
module vs_topk_core
    import vs_pkg::*;
#(
    parameter int LANES  = VS_LANES,
    parameter int EW     = VS_EW,
    parameter int ACCW   = VS_ACCW,
    parameter int VID_W  = VS_VID_W,
    parameter int DIM_W  = VS_DIM_W,
    parameter int ADDR_W = VS_ADDR_W,
    parameter int K      = VS_K
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      mode,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [VID_W-1:0]          vector_count,
    input  logic [DIM_W-1:0]          dim_words,
    vs_topk_core_if.master            mem,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(K+1)-1:0]    topk_count,
    output logic [K*ACCW-1:0]         topk_score,
    output logic [K*VID_W-1:0]        topk_id
);

    vs_state_e              state_q, state_d;
    logic                   mode_q, mode_d;
    logic [VID_W-1:0]       cnt_q, cnt_d;
    logic [DIM_W-1:0]       dim_q, dim_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   rd_en_q, rd_en_d;
    logic [DIM_W-1:0]       word_q, word_d;
    logic [VID_W-1:0]       vec_q, vec_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   clr;
    logic                   last_word, final_issue;

    // Read-side tags travel one cycle behind the strobe to line up with mem_data.
    logic                   p_valid_q, p_valid_d;
    logic                   p_first_q, p_first_d;
    logic                   p_last_q, p_last_d;
    logic                   p_final_q, p_final_d;
    logic [VID_W-1:0]       p_id_q, p_id_d;

    logic signed [ACCW-1:0] acc_q, acc_d;
    logic                   sc_valid_q, sc_valid_d;
    logic                   sc_final_q, sc_final_d;
    logic signed [ACCW-1:0] sc_score_q, sc_score_d;
    logic [VID_W-1:0]       sc_id_q, sc_id_d;

    logic signed [EW-1:0]     a, b;
    logic signed [EW:0]       diff;
    logic signed [2*EW-1:0]   prod;
    logic signed [2*EW+1:0]   sq;
    logic signed [ACCW-1:0]   term, word_sum;

    assign last_word   = (word_q == dim_q - DIM_W'(1));
    assign final_issue = last_word && (vec_q == cnt_q - VID_W'(1));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        dim_d   = dim_q;
        addr_d  = addr_q;
        rd_en_d = rd_en_q;
        word_d  = word_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clr    = 1'b1;
                    mode_d = mode;
                    cnt_d  = vector_count;
                    dim_d  = dim_words;
                    if (vector_count == '0 || dim_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                        rd_en_d = 1'b1;
                        addr_d  = base_addr;
                        word_d  = '0;
                        vec_d   = '0;
                    end
                end
            end
            ST_RUN: begin
                addr_d = addr_q + ADDR_W'(1);
                if (last_word) begin
                    word_d = '0;
                    vec_d  = vec_q + VID_W'(1);
                end else begin
                    word_d = word_q + DIM_W'(1);
                end
                if (final_issue) begin
                    rd_en_d = 1'b0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (sc_valid_q && sc_final_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        word_sum = '0;
        a        = '0;
        b        = '0;
        diff     = '0;
        prod     = '0;
        sq       = '0;
        term     = '0;
        for (int l = 0; l < LANES; l++) begin
            a = mem.mem_data[lane_off(l, EW, 1'b0) +: EW];
            b = mem.mem_data[lane_off(l, EW, 1'b1) +: EW];
            if (mode_q == VS_MODE_L2) begin
                diff = {a[EW-1], a} - {b[EW-1], b};
                sq   = diff * diff;
                term = -(ACCW'(sq));
            end else begin
                prod = a * b;
                term = ACCW'(prod);
            end
            word_sum = word_sum + term;
        end
    end

    always_comb begin
        p_valid_d  = (state_q == ST_RUN);
        p_first_d  = (word_q == '0);
        p_last_d   = last_word;
        p_final_d  = final_issue;
        p_id_d     = vec_q;
        acc_d      = acc_q;
        if (p_valid_q) acc_d = p_first_q ? word_sum : acc_q + word_sum;
        sc_valid_d = p_valid_q && p_last_q;
        sc_final_d = p_valid_q && p_final_q;
        sc_score_d = acc_d;
        sc_id_d    = p_id_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            cnt_q      <= '0;
            dim_q      <= '0;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            word_q     <= '0;
            vec_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            p_valid_q  <= 1'b0;
            p_first_q  <= 1'b0;
            p_last_q   <= 1'b0;
            p_final_q  <= 1'b0;
            p_id_q     <= '0;
            acc_q      <= '0;
            sc_valid_q <= 1'b0;
            sc_final_q <= 1'b0;
            sc_score_q <= '0;
            sc_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            dim_q      <= dim_d;
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
            word_q     <= word_d;
            vec_q      <= vec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            p_valid_q  <= p_valid_d;
            p_first_q  <= p_first_d;
            p_last_q   <= p_last_d;
            p_final_q  <= p_final_d;
            p_id_q     <= p_id_d;
            acc_q      <= acc_d;
            sc_valid_q <= sc_valid_d;
            sc_final_q <= sc_final_d;
            sc_score_q <= sc_score_d;
            sc_id_q    <= sc_id_d;
        end
    end

    vs_topk_insert #(
        .K     (K),
        .ACCW  (ACCW),
        .VID_W (VID_W)
    ) u_insert (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (clr),
        .ins_valid  (sc_valid_q),
        .ins_score  (sc_score_q),
        .ins_id     (sc_id_q),
        .count      (topk_count),
        .score_flat (topk_score),
        .id_flat    (topk_id)
    );

    assign mem.mem_rd_en = rd_en_q;
    assign mem.mem_addr  = addr_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_vs_topk_core.sv
// tb/tb_vs_topk_core.sv - directed self-checking bench for vs_topk_core
module tb_vs_topk_core;
    import vs_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        mode;
    logic [11:0] base_addr;
    logic [9:0]  vector_count;
    logic [7:0]  dim_words;
    logic        busy;
    logic        done;
    logic [2:0]  topk_count;
    logic [127:0] topk_score;
    logic [39:0] topk_id;

    logic [63:0] ram [4096];

    int tests = 0;
    int fails = 0;
    int done_cyc, rd_n, rd_first, rd_last, busy_bad;
    logic [11:0] addr_log [$];

    always #5 clk = ~clk;

    vs_topk_core_if #(.ADDR_W(12), .DATA_W(64)) mem_if ();

    vs_topk_core dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .mode         (mode),
        .base_addr    (base_addr),
        .vector_count (vector_count),
        .dim_words    (dim_words),
        .mem          (mem_if),
        .busy         (busy),
        .done         (done),
        .topk_count   (topk_count),
        .topk_score   (topk_score),
        .topk_id      (topk_id)
    );

    always @(posedge clk) begin
        if (mem_if.mem_rd_en) mem_if.mem_data <= ram[mem_if.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] w1(input int a, input int b);
        logic [63:0] w;
        w = '0;
        w[7:0]  = a[7:0];
        w[15:8] = b[7:0];
        return w;
    endfunction

    function automatic logic [63:0] wall(input int a, input int b);
        logic [63:0] w;
        for (int l = 0; l < 4; l++) begin
            w[16*l +: 8]     = a[7:0];
            w[16*l + 8 +: 8] = b[7:0];
        end
        return w;
    endfunction

    function automatic logic [31:0] sc(input int i);
        return topk_score[i*32 +: 32];
    endfunction

    function automatic logic [31:0] idx(input int i);
        return 32'(topk_id[i*10 +: 10]);
    endfunction

    task automatic run_search(input logic md, input logic [11:0] base, input logic [9:0] cnt,
                              input logic [7:0] dim, input int pulse_cyc);
        int cyc;
        bit got;
        rd_n = 0; rd_first = -1; rd_last = -1; busy_bad = 0; done_cyc = -1;
        addr_log.delete();
        @(posedge clk); #1;
        mode = md; base_addr = base; vector_count = cnt; dim_words = dim; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc < 300) begin
            if (mem_if.mem_rd_en) begin
                rd_n++;
                if (rd_first < 0) rd_first = cyc;
                rd_last = cyc;
                addr_log.push_back(mem_if.mem_addr);
            end
            if (done) begin
                got = 1'b1;
                done_cyc = cyc;
            end else begin
                if (busy !== 1'b1) busy_bad++;
                if (cyc == pulse_cyc) begin
                    start = 1'b1;
                    vector_count = '0;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        chk("busy_low_at_done", 32'(busy), 32'd0);
        chk("busy_high_during_run", 32'(busy_bad), 32'd0);
        @(posedge clk); #1;
        chk("done_single_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; mode = 1'b0;
        base_addr = '0; vector_count = '0; dim_words = '0;
        for (int i = 0; i < 4096; i++) ram[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(mem_if.mem_rd_en), 32'd0);
        chk("rst_addr", 32'(mem_if.mem_addr), 32'd0);
        chk("rst_count", 32'(topk_count), 32'd0);
        chk("rst_score", 32'(|topk_score), 32'd0);
        chk("rst_id", 32'(|topk_id), 32'd0);
        reset_n = 1'b1;

        // Dot mode: scores 10, 30, 20 over two-word candidates
        ram[12'h010] = w1(2, 5); ram[12'h011] = w1(0, 0);
        ram[12'h012] = w1(5, 5); ram[12'h013] = w1(1, 5);
        ram[12'h014] = w1(4, 5); ram[12'h015] = w1(0, 0);
        run_search(VS_MODE_DOT, 12'h010, 10'd3, 8'd2, -1);
        chk("dot_done_cycle", 32'(done_cyc), 32'd9);
        chk("dot_rd_first", 32'(rd_first), 32'd1);
        chk("dot_rd_last", 32'(rd_last), 32'd6);
        chk("dot_rd_count", 32'(rd_n), 32'd6);
        chk("dot_count", 32'(topk_count), 32'd3);
        chk("dot_id0", idx(0), 32'd1);
        chk("dot_id1", idx(1), 32'd2);
        chk("dot_id2", idx(2), 32'd0);
        chk("dot_sc0", sc(0), 32'd30);
        chk("dot_sc1", sc(1), 32'd20);
        chk("dot_sc2", sc(2), 32'd10);
        chk("dot_sc3_empty", sc(3), 32'd0);

        // Tie on equal scores: earlier id ranks higher
        ram[12'h100] = w1(1, 5); ram[12'h101] = w1(1, 5);
        run_search(VS_MODE_DOT, 12'h100, 10'd2, 8'd1, -1);
        chk("tie_count", 32'(topk_count), 32'd2);
        chk("tie_id0", idx(0), 32'd0);
        chk("tie_id1", idx(1), 32'd1);
        chk("tie_sc1", sc(1), 32'd5);

        // Six ascending scores into a four-deep list
        for (int i = 1; i <= 6; i++) ram[12'h200 + i - 1] = w1(1, i);
        run_search(VS_MODE_DOT, 12'h200, 10'd6, 8'd1, -1);
        chk("ovf_count", 32'(topk_count), 32'd4);
        chk("ovf_id0", idx(0), 32'd5);
        chk("ovf_id1", idx(1), 32'd4);
        chk("ovf_id2", idx(2), 32'd3);
        chk("ovf_id3", idx(3), 32'd2);
        chk("ovf_sc3", sc(3), 32'd3);

        // Negated squared L2: 4 lanes * 3 words * -(3-1)^2
        for (int i = 0; i < 3; i++) ram[12'h300 + i] = wall(3, 1);
        run_search(VS_MODE_L2, 12'h300, 10'd1, 8'd3, -1);
        chk("l2_sc0", sc(0), 32'hFFFF_FFD0);
        chk("l2_count", 32'(topk_count), 32'd1);

        // Most-negative elements in dot mode
        ram[12'h310] = wall(-128, -128);
        run_search(VS_MODE_DOT, 12'h310, 10'd1, 8'd1, -1);
        chk("dot_min_sc0", sc(0), 32'd65536);

        // Degenerate start clears prior results and issues no reads
        run_search(VS_MODE_DOT, 12'h020, 10'd0, 8'd2, -1);
        chk("zero_rd_count", 32'(rd_n), 32'd0);
        chk("zero_done_cycle", 32'(done_cyc), 32'd1);
        chk("zero_count", 32'(topk_count), 32'd0);
        chk("zero_sc0", sc(0), 32'd0);

        // Address wrap across the top of memory
        ram[12'hFFE] = w1(1, 1); ram[12'hFFF] = w1(1, 1);
        ram[12'h000] = w1(3, 1); ram[12'h001] = w1(0, 0);
        run_search(VS_MODE_DOT, 12'hFFE, 10'd2, 8'd2, -1);
        chk("wrap_rd_count", 32'(rd_n), 32'd4);
        if (addr_log.size() == 4) begin
            chk("wrap_addr0", 32'(addr_log[0]), 32'hFFE);
            chk("wrap_addr1", 32'(addr_log[1]), 32'hFFF);
            chk("wrap_addr2", 32'(addr_log[2]), 32'h000);
            chk("wrap_addr3", 32'(addr_log[3]), 32'h001);
        end
        chk("wrap_done_cycle", 32'(done_cyc), 32'd7);
        chk("wrap_id0", idx(0), 32'd1);
        chk("wrap_sc1", sc(1), 32'd2);

        // Start pulsed while busy is ignored
        run_search(VS_MODE_DOT, 12'h100, 10'd2, 8'd1, 2);
        chk("busy_start_done_cycle", 32'(done_cyc), 32'd5);
        chk("busy_start_count", 32'(topk_count), 32'd2);
        chk("busy_start_id1", idx(1), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_count", 32'(topk_count), 32'd2);
        chk("hold_sc0", sc(0), 32'd5);

        // Reset asserted in cycle 3 of a run aborts without done
        @(posedge clk); #1;
        mode = VS_MODE_DOT; base_addr = 12'h400; vector_count = 10'd4; dim_words = 8'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rd_en", 32'(mem_if.mem_rd_en), 32'd0);
        chk("abort_addr", 32'(mem_if.mem_addr), 32'd0);
        chk("abort_count", 32'(topk_count), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        begin
            int dn;
            dn = 0;
            for (int i = 0; i < 30; i++) begin
                @(posedge clk); #1;
                if (done) dn++;
                if (busy) dn++;
            end
            chk("abort_no_done", 32'(dn), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
